// File: rtl/zad_8_1.sv
// rtl/zad_8_1.sv - sequential Q5.19 reciprocal of an unsigned integer
// Restoring divider computing floor(2^FRAC_W / x), one quotient bit per clock, MSB first.
module zad_8_1 #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 19,
  parameter int OUT_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  input0,
  output logic             ready,
  output logic [OUT_W-1:0] output0
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [IN_W-1:0]    divisor;
  logic [IN_W-1:0]    rem;
  logic [OUT_W-2:0]   quot;
  logic [CNT_W-1:0]   cnt;
  logic               din;
  logic               last;
  logic [IN_W:0]      rem_sh;
  logic               ge;

  // Dividend 2^FRAC_W has a single set bit; step with cnt=c consumes bit c-1.
  assign din    = (cnt == CNT_W'(FRAC_W + 1));
  assign last   = (cnt == CNT_W'(1));
  assign rem_sh = {rem, din};
  // With divisor 0 every step succeeds, so the quotient saturates to all ones.
  assign ge     = (rem_sh >= {1'b0, divisor});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (last)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= '0;
      rem     <= '0;
      quot    <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
      output0 <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            divisor <= input0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= CNT_W'(OUT_W);
          end
        end
        BUSY: begin
          rem  <= ge ? IN_W'(rem_sh - {1'b0, divisor}) : rem_sh[IN_W-1:0];
          quot <= {quot[OUT_W-3:0], ge};
          cnt  <= cnt - CNT_W'(1);
          if (last) begin
            output0 <= {quot, ge};
            ready   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zad_8_1.sv
// tb/tb_zad_8_1.sv - self-checking bench for zad_8_1
// Table vectors, randomized operands against an arithmetic model, and handshake corner cases.
module tb_zad_8_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] input0;
  logic        ready;
  logic [23:0] output0;

  int tests = 0;
  int fails = 0;

  zad_8_1 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .input0  (input0),
    .ready   (ready),
    .output0 (output0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [23:0] exp;
  } vec_t;

  function automatic logic [23:0] model(input logic [15:0] x);
    longint unsigned q;
    if (x == 16'd0) return 24'hFFFFFF;
    q = (64'd1 << 19) / longint'(x);
    return q[23:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for ready, counting negedges; returns count including the starting one.
  task automatic wait_ready(input int n0, output int n);
    n = n0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Pulses start for one cycle; latency counts negedges from the driving negedge.
  task automatic run_op(input logic [15:0] x, input string name);
    int n;
    @(negedge clk);
    start  = 1'b1;
    input0 = x;
    @(negedge clk);
    start = 1'b0;
    wait_ready(1, n);
    check({name, "_lat"}, 32'(n), 32'd25);
    check({name, "_val"}, 32'(output0), 32'(model(x)));
    @(negedge clk);
    check({name, "_pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    vec_t tbl[10];
    int   n;
    int   cnt_rdy;
    logic [15:0] x;

    tbl[0] = '{16'd1,     24'h080000};
    tbl[1] = '{16'd2,     24'h040000};
    tbl[2] = '{16'd3,     24'h02AAAA};
    tbl[3] = '{16'd7,     24'h012492};
    tbl[4] = '{16'd65535, 24'h000008};
    tbl[5] = '{16'd0,     24'hFFFFFF};
    tbl[6] = '{16'd10,    24'h00CCCC};
    tbl[7] = '{16'd16,    24'h008000};
    tbl[8] = '{16'd60000, 24'h000008};
    tbl[9] = '{16'd4096,  24'h000080};

    rst    = 1'b1;
    start  = 1'b0;
    input0 = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_out", 32'(output0), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("tbl_model", 32'(model(tbl[i].x)), 32'(tbl[i].exp));
      run_op(tbl[i].x, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_exp", i), 32'(output0), 32'(tbl[i].exp));
    end

    for (int i = 0; i < 20; i++) begin
      x = (i < 10) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(0, 65535));
      run_op(x, $sformatf("rnd%0d", i));
    end

    // Self-handshake sweep: start held high, operand advanced on each ready.
    @(negedge clk);
    start  = 1'b1;
    input0 = 16'd1;
    for (int v = 1; v <= 8; v++) begin
      @(negedge clk);
      wait_ready(1, n);
      check($sformatf("sweep%0d_lat", v), 32'(n), 32'd25);
      check($sformatf("sweep%0d_val", v), 32'(output0), 32'(model(16'(v))));
      input0 = 16'(v + 1);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sweep_idle", 32'(ready), 32'd0);
    repeat (30) @(negedge clk);

    // Operand and start toggled while busy must not disturb the latched operation.
    @(negedge clk);
    start  = 1'b1;
    input0 = 16'd5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      input0 = 16'($urandom);
    end while (!ready && n < 60);
    check("busy_lat", 32'(n), 32'd25);
    check("busy_val", 32'(output0), 32'(model(16'd5)));
    input0 = 16'd9;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      input0 = 16'($urandom);
    end while (!ready && n < 60);
    check("b2b_lat", 32'(n), 32'd25);
    check("b2b_val", 32'(output0), 32'(model(16'd9)));
    start = 1'b0;
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-operation.
    run_op(16'd3, "pre_rst");
    @(negedge clk);
    start  = 1'b1;
    input0 = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_out", 32'(output0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_rdy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) cnt_rdy++;
    end
    check("arst_no_pulse", 32'(cnt_rdy), 32'd0);
    check("arst_out_hold", 32'(output0), 32'd0);
    run_op(16'd3, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zad_8_1.md
Name: zad_8_1

Overview:
Sequential fixed-point reciprocal unit. Takes an unsigned 16-bit integer and returns 1/x as an unsigned Q5.19 value (24 bits, bit indices 4 down to -19), using a start/ready handshake. Internally it is an iterative restoring divider computing floor(2^19 / x), one quotient bit per clock. It serves as a standalone arithmetic helper block behind a simple request/response interface.

Parameters:
IN_W, 16, width of the unsigned integer operand
FRAC_W, 19, number of fractional bits in the result
OUT_W, 24, result width (5 integer + 19 fractional bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled at posedge while idle
input0  input  16  unsigned operand x; captured on accepted start
ready  output  1  one-cycle pulse: output0 holds a new result
output0  output  24 ([4:-19])  unsigned Q5.19 value of 1/x, truncated toward zero

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst is high: state=IDLE, ready=0, output0=0, internal registers cleared. rst asserted mid-operation aborts the operation without producing a ready pulse.
- States: IDLE and BUSY.
- IDLE: at a posedge with start=1, latch input0 into the divisor register, clear the quotient and the partial remainder, load iteration counter=OUT_W, and go to BUSY. A start that arrives in the same cycle that ready is high is accepted, so back-to-back operation works.
- BUSY: performs one restoring-division step per clock on dividend 2^FRAC_W, shifting in zeros, over OUT_W=24 steps, producing quotient bits MSB first. start is ignored while BUSY, and input0 may change freely without affecting the operation in progress.
- Completion: on the edge of the last step, output0 is loaded with the quotient, ready is set to 1 and the state returns to IDLE. ready drops to 0 on the next edge.
- Latency: start sampled at edge k -> ready=1 and output0 valid immediately after edge k+24. Throughput is one result per 25 cycles under self-handshake (start <= ready).
- output0 holds its value until the next completion.
- Arithmetic: output0 = floor(2^19 / x). Maximum value is 2^19 (x=1), which fits in 24 bits. There is no rounding; fractional truncation gives at most 1 LSB (2^-19) error.
- Divide by zero: x=0 runs the same latency and then returns output0 = 24'hFFFFFF (saturated).
- ready is registered and glitch-free, and is never high for two consecutive cycles.

Test Plan:
- Reset: assert rst asynchronously mid-BUSY -> ready=0 and output0=0 immediately, no pulse after release; a fresh start then works normally.
- x=3, start pulse -> 24 cycles later ready pulses for exactly 1 cycle, output0=24'h02AAAA (0.333332).
- Self-handshake sweep starting at x=1 (start <= ready, input0 incremented on each ready) -> x=1: 24'h080000; x=2: 24'h040000; x=7: 74898 (24'h012492). Each result is within 2^-19 of 1/x.
- x=65535 -> output0=8. x=0 -> output0=24'hFFFFFF after the normal latency.
- Change input0 and hold start=1 while BUSY -> result reflects the latched operand only, and no extra operation starts until IDLE.
- Back-to-back: start high in the ready cycle -> the next operation is accepted, and its ready arrives 24 cycles later.
